// File: rtl/pipeline_stage_tracker_pkg.sv
// Shared CPU types, opcode/funct codes, pipeline-latch control record and
// helper functions for the pipeline stage tracker.
package pipeline_stage_tracker_pkg;

  typedef logic [5:0]  opcode_t;
  typedef logic [5:0]  funct_t;
  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  localparam opcode_t OP_RTYPE = 6'h00;
  localparam opcode_t OP_J     = 6'h02;
  localparam opcode_t OP_JAL   = 6'h03;
  localparam opcode_t OP_BEQ   = 6'h04;
  localparam opcode_t OP_BNE   = 6'h05;
  localparam opcode_t OP_ADDI  = 6'h08;
  localparam opcode_t OP_ADDIU = 6'h09;
  localparam opcode_t OP_SLTI  = 6'h0A;
  localparam opcode_t OP_SLTIU = 6'h0B;
  localparam opcode_t OP_ANDI  = 6'h0C;
  localparam opcode_t OP_ORI   = 6'h0D;
  localparam opcode_t OP_XORI  = 6'h0E;
  localparam opcode_t OP_LUI   = 6'h0F;
  localparam opcode_t OP_LW    = 6'h23;
  localparam opcode_t OP_LL    = 6'h30;
  localparam opcode_t OP_SC    = 6'h38;
  localparam opcode_t OP_HALT  = 6'h3F;

  localparam funct_t   FN_JR  = 6'h08;
  localparam regbits_t REG_RA = 5'd31;

  // Control shadow carried by each pipeline latch.
  typedef struct packed {
    logic     valid;
    word_t    instr;
    opcode_t  op;
    logic     wr_en;
    regbits_t wr_addr;
    logic     zero;
  } stage_ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } drain_state_t;

  // True when the opcode/funct pair writes a register.
  function automatic logic op_writes_reg(input opcode_t op, input funct_t funct);
    logic w;
    w = 1'b0;
    case (op)
      OP_RTYPE: w = (funct != FN_JR);
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_SLTI, OP_SLTIU, OP_LW, OP_LL, OP_SC, OP_JAL: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  // Even parity over a whole latch record.
  function automatic logic ctrl_parity(input stage_ctrl_t s);
    return ^s;
  endfunction

endpackage

// File: rtl/pipeline_stage_tracker_stage_ctrl_decode.sv
// Combinational decode of write-back control from instruction fields.
module stage_ctrl_decode
  import pipeline_stage_tracker_pkg::*;
(
  input  opcode_t  op_i,
  input  funct_t   funct_i,
  input  regbits_t rt_i,
  input  regbits_t rd_i,
  output logic     reg_wr_en_o,
  output logic     reg_dst_o,
  output regbits_t wr_addr_o
);

  // Pick the destination register, then suppress writes to $zero.
  always_comb begin
    reg_dst_o   = (op_i == OP_RTYPE);
    wr_addr_o   = rt_i;
    reg_wr_en_o = 1'b0;
    if (op_i == OP_JAL) begin
      wr_addr_o = REG_RA;
    end else if (reg_dst_o) begin
      wr_addr_o = rd_i;
    end else begin
      wr_addr_o = rt_i;
    end
    reg_wr_en_o = op_writes_reg(op_i, funct_i) && (wr_addr_o != 5'd0);
  end

endmodule

// File: rtl/pipeline_stage_tracker.sv
// Pipeline-latch control shadows, halt-drain FSM and performance counters;
// the datapath-facing end of the hazard unit interface.
module pipeline_stage_tracker
  import pipeline_stage_tracker_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [31:0]      fetch_instruction,
  input  logic             execute_alu_zero,
  input  logic             fetch_decode_flush,
  input  logic             decode_execute_flush,
  input  logic             execute_memory_flush,
  input  logic             memory_write_back_flush,
  input  logic             fetch_decode_enable,
  input  logic             decode_execute_enable,
  input  logic             execute_memory_enable,
  input  logic             memory_write_back_enable,
  output logic             hu_ihit,
  output logic             hu_dhit,
  output logic [31:0]      decode_instruction,
  output logic [4:0]       decode_rs,
  output logic [4:0]       decode_rt,
  output logic             decode_reg_wr_en,
  output logic             decode_reg_dst,
  output logic             execute_reg_wr_en,
  output logic [4:0]       execute_reg_wr_addr,
  output logic [5:0]       execute_op_code,
  output logic             memory_reg_wr_en,
  output logic [4:0]       memory_reg_wr_addr,
  output logic [5:0]       memory_op_code,
  output logic             memory_beq,
  output logic             memory_bne,
  output logic             memory_jump_en,
  output logic             memory_jump_r_en,
  output logic             memory_pc_src,
  output logic [3:0]       stage_valid,
  output logic [3:0]       stage_parity,
  output logic             halt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_ctrl_t  if_id_q, if_id_d, id_ex_q, id_ex_d;
  stage_ctrl_t  ex_mem_q, ex_mem_d, mem_wb_q, mem_wb_d;
  drain_state_t state_q, state_d;
  logic         halt_q, halt_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, stall_q, stall_d, flush_q, flush_d;

  logic     dec_wr_en, dec_reg_dst;
  regbits_t dec_wr_addr;
  logic     count_en, any_flush, halt_leaving;

  stage_ctrl_decode u_if_id_decode (
    .op_i        (if_id_q.instr[31:26]),
    .funct_i     (if_id_q.instr[5:0]),
    .rt_i        (if_id_q.instr[20:16]),
    .rd_i        (if_id_q.instr[15:11]),
    .reg_wr_en_o (dec_wr_en),
    .reg_dst_o   (dec_reg_dst),
    .wr_addr_o   (dec_wr_addr)
  );

  // Latch next-state: flush beats enable, enable beats hold.
  always_comb begin
    if_id_d  = if_id_q;
    id_ex_d  = id_ex_q;
    ex_mem_d = ex_mem_q;
    mem_wb_d = mem_wb_q;

    if (fetch_decode_flush) begin
      if_id_d = '0;
    end else if (fetch_decode_enable) begin
      if_id_d       = '0;
      if_id_d.valid = ihit;
      if_id_d.instr = fetch_instruction;
      if_id_d.op    = fetch_instruction[31:26];
    end else begin
      if_id_d = if_id_q;
    end

    // A bubble in IF/ID must never carry a register write downstream.
    if (decode_execute_flush) begin
      id_ex_d = '0;
    end else if (decode_execute_enable) begin
      id_ex_d.valid   = if_id_q.valid;
      id_ex_d.instr   = if_id_q.instr;
      id_ex_d.op      = if_id_q.op;
      id_ex_d.wr_en   = dec_wr_en & if_id_q.valid;
      id_ex_d.wr_addr = dec_wr_addr;
      id_ex_d.zero    = 1'b0;
    end else begin
      id_ex_d = id_ex_q;
    end

    if (execute_memory_flush) begin
      ex_mem_d = '0;
    end else if (execute_memory_enable) begin
      ex_mem_d      = id_ex_q;
      ex_mem_d.zero = execute_alu_zero;
    end else begin
      ex_mem_d = ex_mem_q;
    end

    if (memory_write_back_flush) begin
      mem_wb_d = '0;
    end else if (memory_write_back_enable) begin
      mem_wb_d = ex_mem_q;
    end else begin
      mem_wb_d = mem_wb_q;
    end
  end

  // A valid HALT actually advancing out of EX/MEM starts the drain.
  assign halt_leaving = ex_mem_q.valid && (ex_mem_q.op == OP_HALT) &&
                        memory_write_back_enable && !memory_write_back_flush;

  // Halt-drain FSM next-state and sticky halt flag.
  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    case (state_q)
      ST_RUN: begin
        if (halt_leaving) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_HALTED;
        halt_d  = 1'b1;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
        halt_d  = 1'b1;
      end
      default: begin
        state_d = ST_HALTED;
        halt_d  = 1'b1;
      end
    endcase
  end

  assign count_en  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign any_flush = fetch_decode_flush | decode_execute_flush |
                     execute_memory_flush | memory_write_back_flush;

  // Saturating performance counters, frozen once halted.
  always_comb begin
    cycle_d = cycle_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (count_en && (cycle_q != CNT_MAX)) begin
      cycle_d = cycle_q + CNT_ONE;
    end else begin
      cycle_d = cycle_q;
    end
    if (count_en && !fetch_decode_enable && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
    if (count_en && any_flush && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_ONE;
    end else begin
      flush_d = flush_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
      state_q  <= ST_RUN;
      halt_q   <= 1'b0;
      cycle_q  <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      state_q  <= state_d;
      halt_q   <= halt_d;
      cycle_q  <= cycle_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign hu_ihit             = ihit;
  assign hu_dhit             = dhit;
  assign decode_instruction  = if_id_q.instr;
  assign decode_rs           = if_id_q.instr[25:21];
  assign decode_rt           = if_id_q.instr[20:16];
  assign decode_reg_wr_en    = dec_wr_en;
  assign decode_reg_dst      = dec_reg_dst;
  assign execute_reg_wr_en   = id_ex_q.wr_en;
  assign execute_reg_wr_addr = id_ex_q.wr_addr;
  assign execute_op_code     = id_ex_q.op;
  assign memory_reg_wr_en    = ex_mem_q.wr_en;
  assign memory_reg_wr_addr  = ex_mem_q.wr_addr;
  assign memory_op_code      = ex_mem_q.op;
  assign memory_beq          = (ex_mem_q.op == OP_BEQ);
  assign memory_bne          = (ex_mem_q.op == OP_BNE);
  assign memory_jump_en      = (ex_mem_q.op == OP_J) || (ex_mem_q.op == OP_JAL);
  assign memory_jump_r_en    = (ex_mem_q.op == OP_RTYPE) && (ex_mem_q.instr[5:0] == FN_JR);
  assign memory_pc_src       = ex_mem_q.valid &&
                               ((memory_beq && ex_mem_q.zero) || (memory_bne && !ex_mem_q.zero));
  assign stage_valid         = {mem_wb_q.valid, ex_mem_q.valid, id_ex_q.valid, if_id_q.valid};
  assign stage_parity        = {ctrl_parity(mem_wb_q), ctrl_parity(ex_mem_q),
                                ctrl_parity(id_ex_q), ctrl_parity(if_id_q)};
  assign halt                = halt_q;
  assign cycle_cnt           = cycle_q;
  assign stall_cnt           = stall_q;
  assign flush_cnt           = flush_q;

endmodule

// File: tb/tb_pipeline_stage_tracker.sv
// Directed, table-driven bench for pipeline_stage_tracker.
module tb_pipeline_stage_tracker;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit, dhit, execute_alu_zero;
  logic [31:0] fetch_instruction;
  logic [3:0]  fl, en;
  logic        hu_ihit, hu_dhit;
  logic [31:0] decode_instruction;
  logic [4:0]  decode_rs, decode_rt;
  logic        decode_reg_wr_en, decode_reg_dst;
  logic        execute_reg_wr_en, memory_reg_wr_en;
  logic [4:0]  execute_reg_wr_addr, memory_reg_wr_addr;
  logic [5:0]  execute_op_code, memory_op_code;
  logic        memory_beq, memory_bne, memory_jump_en, memory_jump_r_en, memory_pc_src;
  logic [3:0]  stage_valid, stage_parity;
  logic        halt;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  pipeline_stage_tracker #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .fetch_instruction(fetch_instruction), .execute_alu_zero(execute_alu_zero),
    .fetch_decode_flush(fl[0]), .decode_execute_flush(fl[1]),
    .execute_memory_flush(fl[2]), .memory_write_back_flush(fl[3]),
    .fetch_decode_enable(en[0]), .decode_execute_enable(en[1]),
    .execute_memory_enable(en[2]), .memory_write_back_enable(en[3]),
    .hu_ihit(hu_ihit), .hu_dhit(hu_dhit),
    .decode_instruction(decode_instruction), .decode_rs(decode_rs), .decode_rt(decode_rt),
    .decode_reg_wr_en(decode_reg_wr_en), .decode_reg_dst(decode_reg_dst),
    .execute_reg_wr_en(execute_reg_wr_en), .execute_reg_wr_addr(execute_reg_wr_addr),
    .execute_op_code(execute_op_code),
    .memory_reg_wr_en(memory_reg_wr_en), .memory_reg_wr_addr(memory_reg_wr_addr),
    .memory_op_code(memory_op_code), .memory_beq(memory_beq), .memory_bne(memory_bne),
    .memory_jump_en(memory_jump_en), .memory_jump_r_en(memory_jump_r_en),
    .memory_pc_src(memory_pc_src), .stage_valid(stage_valid), .stage_parity(stage_parity),
    .halt(halt), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // flags = {beq, bne, jump_en, jump_r_en, pc_src}; fl/en bit0 = IF/ID .. bit3 = MEM/WB
  typedef struct {
    logic [31:0] instr;
    logic        ihit;
    logic        zero;
    logic [3:0]  fl;
    logic [3:0]  en;
    logic        ex_wr;
    logic [4:0]  ex_addr;
    logic [5:0]  ex_op;
    logic        mem_wr;
    logic [4:0]  mem_addr;
    logic [5:0]  mem_op;
    logic [4:0]  flags;
    logic [3:0]  valid;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] instr, input logic ih, input logic z,
                      input logic [3:0] f, input logic [3:0] e);
    fetch_instruction = instr;
    ihit = ih;
    execute_alu_zero = z;
    fl = f;
    en = e;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h20030005, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0, 5'd0,  6'h00, 1'b0, 5'd0,  6'h00, 5'b00000, 4'b0001};
    vecs[1]  = '{32'h10000000, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 5'd3,  6'h08, 1'b0, 5'd0,  6'h00, 5'b00000, 4'b0011};
    vecs[2]  = '{32'h14000000, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0, 5'd0,  6'h04, 1'b1, 5'd3,  6'h08, 5'b00000, 4'b0111};
    vecs[3]  = '{32'h0C000010, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0, 5'd0,  6'h05, 1'b0, 5'd0,  6'h04, 5'b10001, 4'b1111};
    vecs[4]  = '{32'h03E00008, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1, 5'd31, 6'h03, 1'b0, 5'd0,  6'h05, 5'b01000, 4'b1111};
    vecs[5]  = '{32'h00002820, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0, 5'd0,  6'h00, 1'b1, 5'd31, 6'h03, 5'b00100, 4'b1111};
    vecs[6]  = '{32'h00000000, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 5'd5,  6'h00, 1'b0, 5'd0,  6'h00, 5'b00010, 4'b1111};
    vecs[7]  = '{32'h8C040000, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0, 5'd0,  6'h00, 1'b1, 5'd5,  6'h00, 5'b00000, 4'b1111};
    vecs[8]  = '{32'h00000000, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 5'd4,  6'h23, 1'b0, 5'd0,  6'h00, 5'b00000, 4'b1111};
    vecs[9]  = '{32'h00000000, 1'b1, 1'b0, 4'b0010, 4'b1111, 1'b0, 5'd0,  6'h00, 1'b1, 5'd4,  6'h23, 5'b00000, 4'b1101};
    vecs[10] = '{32'h00000000, 1'b1, 1'b0, 4'b0100, 4'b1111, 1'b0, 5'd0,  6'h00, 1'b0, 5'd0,  6'h00, 5'b00000, 4'b1011};
    vecs[11] = '{32'h20030005, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 5'd0,  6'h00, 1'b0, 5'd0,  6'h00, 5'b00000, 4'b0110};

    dhit = 1'b1;
    fetch_instruction = 32'h0;
    ihit = 1'b0;
    execute_alu_zero = 1'b0;
    fl = 4'b0000;
    en = 4'b0000;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Reset state: all-zero IF/ID decodes as an RTYPE NOP writing $zero.
    check("rst_valid", 0, {28'h0, stage_valid}, 32'h0);
    check("rst_dinstr", 0, decode_instruction, 32'h0);
    check("rst_regdst", 0, {31'h0, decode_reg_dst}, 32'h1);
    check("rst_dwren", 0, {31'h0, decode_reg_wr_en}, 32'h0);
    check("rst_halt", 0, {31'h0, halt}, 32'h0);
    check("rst_cycle", 0, cycle_cnt, 32'h0);
    check("rst_stall", 0, stall_cnt, 32'h0);
    check("fwd_dhit", 0, {31'h0, hu_dhit}, 32'h1);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].instr, vecs[i].ihit, vecs[i].zero, vecs[i].fl, vecs[i].en);
      check("ex_wr",    i, {31'h0, execute_reg_wr_en}, {31'h0, vecs[i].ex_wr});
      check("ex_addr",  i, {27'h0, execute_reg_wr_addr}, {27'h0, vecs[i].ex_addr});
      check("ex_op",    i, {26'h0, execute_op_code}, {26'h0, vecs[i].ex_op});
      check("mem_wr",   i, {31'h0, memory_reg_wr_en}, {31'h0, vecs[i].mem_wr});
      check("mem_addr", i, {27'h0, memory_reg_wr_addr}, {27'h0, vecs[i].mem_addr});
      check("mem_op",   i, {26'h0, memory_op_code}, {26'h0, vecs[i].mem_op});
      check("mem_flags", i,
            {27'h0, memory_beq, memory_bne, memory_jump_en, memory_jump_r_en, memory_pc_src},
            {27'h0, vecs[i].flags});
      check("valid",    i, {28'h0, stage_valid}, {28'h0, vecs[i].valid});
      check("fwd_ihit", i, {31'h0, hu_ihit}, {31'h0, vecs[i].ihit});
    end
    check("tbl_cycle", 0, cycle_cnt, 32'd12);
    check("tbl_stall", 0, stall_cnt, 32'd0);
    check("tbl_flush", 0, flush_cnt, 32'd2);

    // IF/ID decode of ADD $5,$6,$7, then a 3-cycle fetch stall.
    step(32'h00C72820, 1'b1, 1'b0, 4'b0000, 4'b1111);
    check("dec_rs", 0, {27'h0, decode_rs}, 32'd6);
    check("dec_rt", 0, {27'h0, decode_rt}, 32'd7);
    check("dec_dst", 0, {31'h0, decode_reg_dst}, 32'h1);
    check("dec_wren", 0, {31'h0, decode_reg_wr_en}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(32'h8C040000, 1'b1, 1'b0, 4'b0000, 4'b1110);
      check("stall_hold", i, decode_instruction, 32'h00C72820);
    end
    check("stall_cnt", 0, stall_cnt, 32'd3);
    check("stall_cycle", 0, cycle_cnt, 32'd16);

    // HALT drains: halt rises one edge after it leaves EX/MEM.
    step(32'hFFFFFFFF, 1'b1, 1'b0, 4'b0000, 4'b1111);
    step(32'h00000000, 1'b1, 1'b0, 4'b0000, 4'b1111);
    step(32'h00000000, 1'b1, 1'b0, 4'b0000, 4'b1111);
    check("halt_in_mem", 0, {26'h0, memory_op_code}, 32'h3F);
    check("halt_early", 0, {31'h0, halt}, 32'h0);
    step(32'h00000000, 1'b1, 1'b0, 4'b0000, 4'b1111);
    check("halt_drain", 0, {31'h0, halt}, 32'h0);
    step(32'h00000000, 1'b1, 1'b0, 4'b0000, 4'b1111);
    check("halt_set", 0, {31'h0, halt}, 32'h1);
    check("halt_cycle", 0, cycle_cnt, 32'd21);
    for (int i = 0; i < 3; i++) begin
      step(32'h00000000, 1'b1, 1'b0, 4'b0001, 4'b1110);
    end
    check("frz_halt", 0, {31'h0, halt}, 32'h1);
    check("frz_cycle", 0, cycle_cnt, 32'd21);
    check("frz_stall", 0, stall_cnt, 32'd3);
    check("frz_flush", 0, flush_cnt, 32'd2);

    // Asynchronous reset mid-operation, then normal restart.
    RST = 1'b1;
    #2;
    check("arst_halt", 0, {31'h0, halt}, 32'h0);
    check("arst_cycle", 0, cycle_cnt, 32'h0);
    check("arst_flush", 0, flush_cnt, 32'h0);
    check("arst_valid", 0, {28'h0, stage_valid}, 32'h0);
    RST = 1'b0;
    step(32'h20030005, 1'b1, 1'b0, 4'b0000, 4'b1111);
    check("post_cycle", 0, cycle_cnt, 32'd1);
    check("post_valid", 0, {28'h0, stage_valid}, 32'h1);
    check("post_dinstr", 0, decode_instruction, 32'h20030005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
